vga_rx_decoder: RTL and testbench

//  Receive-side decoder for the VGA output stream (sync/DE/RGB565): recovers per-pixel x/y, measures

---
 rtl/vga_rx_decoder.sv | 210 +++++++++++++++++++++
 tb/tb_vga_rx_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_decoder.sv
// Loopback VGA receive monitor: recovers pixel x/y, measures line/frame timing, tracks lock, frame checksum.
// Pixel path latency 2 cycles from vga_* inputs; no backpressure (pure observer, never stalls the source).
module vga_rx_decoder #(
  parameter int   CW          = 12,
  parameter logic HS_ACTIVE   = 1'b0,
  parameter logic VS_ACTIVE   = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic          pix_clk,
  input  logic          pix_rst,
  input  logic          vga_hsync,
  input  logic          vga_vsync,
  input  logic          vga_de,
  input  logic [15:0]   vga_rgb,
  output logic          rx_valid,
  output logic [CW-1:0] rx_x,
  output logic [CW-1:0] rx_y,
  output logic [15:0]   rx_rgb,
  output logic          frame_done,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_active,
  output logic [31:0]   frame_chk,
  output logic          locked,
  output logic [2:0]    err_flags
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CONE = {{(CW-1){1'b0}}, 1'b1};
  localparam int            LW   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [LW-1:0] LF   = LW'(LOCK_FRAMES);
  localparam logic [LW-1:0] LONE = {{(LW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_TRACK    = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + CONE;
  endfunction

  // input sampling stages
  logic          hs1_q, hs2_q, vs1_q, vs2_q, de1_q, de2_q;
  logic [15:0]   rgb1_q;

  // running counters
  logic [CW-1:0] x_q, x_d, x_cur;
  logic [CW-1:0] y_q, y_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] h_meas_q, h_meas_d;
  logic [CW-1:0] vcnt_q, vcnt_d, v_tot_now;
  logic [CW-1:0] hact_q, hact_d;
  logic [CW-1:0] first_len_q, first_len_d;
  logic          have_first_q, have_first_d;
  logic [31:0]   chk_q, chk_d;
  logic [2:0]    err_q, err_d, err_now, err_frame;
  logic          armed_q, armed_d;
  logic          len_err, sat_hit;

  // output registers
  logic          rx_valid_q, rx_valid_d;
  logic [CW-1:0] rx_x_q, rx_x_d, rx_y_q, rx_y_d;
  logic [15:0]   rx_rgb_q, rx_rgb_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [CW-1:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic [31:0]   frame_chk_q, frame_chk_d;
  logic [2:0]    err_flags_q, err_flags_d;

  // lock tracking
  lock_state_e   state_q, state_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [CW-1:0] ref_ht_q, ref_ha_q, ref_vt_q, ref_va_q;
  logic          ref_load, meas_match;

  logic hs_edge, vs_edge, de_rise, de_fall, fe;

  assign hs_edge = (hs1_q == HS_ACTIVE) && (hs2_q != HS_ACTIVE);
  assign vs_edge = (vs1_q == VS_ACTIVE) && (vs2_q != VS_ACTIVE);
  assign de_rise = de1_q & ~de2_q;
  assign de_fall = ~de1_q & de2_q;
  assign fe      = vs_edge & armed_q;

  always_comb begin
    x_cur        = de_rise ? '0 : x_q;
    x_d          = de1_q ? sat_inc(x_cur) : x_q;
    y_d          = vs_edge ? '0 : (de_fall ? sat_inc(y_q) : y_q);
    hcnt_d       = hs_edge ? CONE : sat_inc(hcnt_q);
    h_meas_d     = hs_edge ? hcnt_q : h_meas_q;
    // an hsync edge coincident with vsync belongs to the frame being closed
    v_tot_now    = hs_edge ? sat_inc(vcnt_q) : vcnt_q;
    vcnt_d       = vs_edge ? '0 : v_tot_now;
    hact_d       = de_fall ? x_q : hact_q;
    len_err      = de_fall && have_first_q && (x_q != first_len_q);
    first_len_d  = (de_fall && !have_first_q) ? x_q : first_len_q;
    have_first_d = vs_edge ? 1'b0 : (de_fall ? 1'b1 : have_first_q);
    sat_hit      = (x_q == CMAX) || (y_q == CMAX) || (hcnt_q == CMAX) || (vcnt_q == CMAX);
    err_now      = {sat_hit, de1_q && (vs1_q == VS_ACTIVE), len_err};
    err_frame    = err_q | err_now;
    err_d        = vs_edge ? 3'b000 : err_frame;
    chk_d        = chk_q;
    if (vs_edge) begin
      chk_d = '0;
    end else if (de1_q) begin
      chk_d = {chk_q[30:0], chk_q[31]} ^ {16'h0000, rgb1_q};
    end
    armed_d      = armed_q | vs_edge;

    rx_valid_d   = de1_q;
    rx_x_d       = de1_q ? x_cur  : rx_x_q;
    rx_y_d       = de1_q ? y_q    : rx_y_q;
    rx_rgb_d     = de1_q ? rgb1_q : rx_rgb_q;

    frame_done_d = fe;
    h_total_d    = fe ? h_meas_d  : h_total_q;
    h_active_d   = fe ? hact_q    : h_active_q;
    v_total_d    = fe ? v_tot_now : v_total_q;
    v_active_d   = fe ? y_q       : v_active_q;
    frame_chk_d  = fe ? chk_q     : frame_chk_q;
    err_flags_d  = fe ? err_frame : err_flags_q;
  end

  assign meas_match = (h_meas_d == ref_ht_q) && (hact_q == ref_ha_q) &&
                      (v_tot_now == ref_vt_q) && (y_q == ref_va_q);

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    ref_load = 1'b0;
    if (fe) begin
      case (state_q)
        ST_UNLOCKED: begin
          state_d  = ST_TRACK;
          lcnt_d   = LONE;
          ref_load = 1'b1;
        end
        ST_TRACK: begin
          if (meas_match) begin
            lcnt_d = lcnt_q + LONE;
            if ((lcnt_q + LONE) >= LF) begin
              state_d = ST_LOCKED;
            end
          end else begin
            lcnt_d   = LONE;
            ref_load = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!meas_match || (err_frame != 3'b000)) begin
            state_d  = ST_TRACK;
            lcnt_d   = LONE;
            ref_load = 1'b1;
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
          lcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      hs1_q <= 1'b0; hs2_q <= 1'b0; vs1_q <= 1'b0; vs2_q <= 1'b0;
      de1_q <= 1'b0; de2_q <= 1'b0; rgb1_q <= '0;
      x_q <= '0; y_q <= '0; hcnt_q <= '0; h_meas_q <= '0; vcnt_q <= '0;
      hact_q <= '0; first_len_q <= '0; have_first_q <= 1'b0;
      chk_q <= '0; err_q <= '0; armed_q <= 1'b0;
      rx_valid_q <= 1'b0; rx_x_q <= '0; rx_y_q <= '0; rx_rgb_q <= '0;
      frame_done_q <= 1'b0; h_total_q <= '0; h_active_q <= '0;
      v_total_q <= '0; v_active_q <= '0; frame_chk_q <= '0; err_flags_q <= '0;
      state_q <= ST_UNLOCKED; lcnt_q <= '0;
      ref_ht_q <= '0; ref_ha_q <= '0; ref_vt_q <= '0; ref_va_q <= '0;
    end else begin
      hs1_q <= vga_hsync; hs2_q <= hs1_q;
      vs1_q <= vga_vsync; vs2_q <= vs1_q;
      de1_q <= vga_de;    de2_q <= de1_q;
      rgb1_q <= vga_rgb;
      x_q <= x_d; y_q <= y_d; hcnt_q <= hcnt_d; h_meas_q <= h_meas_d; vcnt_q <= vcnt_d;
      hact_q <= hact_d; first_len_q <= first_len_d; have_first_q <= have_first_d;
      chk_q <= chk_d; err_q <= err_d; armed_q <= armed_d;
      rx_valid_q <= rx_valid_d; rx_x_q <= rx_x_d; rx_y_q <= rx_y_d; rx_rgb_q <= rx_rgb_d;
      frame_done_q <= frame_done_d; h_total_q <= h_total_d; h_active_q <= h_active_d;
      v_total_q <= v_total_d; v_active_q <= v_active_d; frame_chk_q <= frame_chk_d;
      err_flags_q <= err_flags_d;
      state_q <= state_d; lcnt_q <= lcnt_d;
      if (ref_load) begin
        ref_ht_q <= h_meas_d; ref_ha_q <= hact_q; ref_vt_q <= v_tot_now; ref_va_q <= y_q;
      end
    end
  end

  assign rx_valid   = rx_valid_q;
  assign rx_x       = rx_x_q;
  assign rx_y       = rx_y_q;
  assign rx_rgb     = rx_rgb_q;
  assign frame_done = frame_done_q;
  assign h_total    = h_total_q;
  assign h_active   = h_active_q;
  assign v_total    = v_total_q;
  assign v_active   = v_active_q;
  assign frame_chk  = frame_chk_q;
  assign err_flags  = err_flags_q;
  assign locked     = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder: 20x10 frame generator with directed variations, scoreboard-checked.
module tb_vga_rx_decoder;
  localparam int CW = 12;
  localparam int NF = 15;

  logic          pix_clk = 1'b0;
  logic          pix_rst;
  logic          vga_hsync, vga_vsync, vga_de;
  logic [15:0]   vga_rgb;
  logic          rx_valid, frame_done, locked;
  logic [CW-1:0] rx_x, rx_y, h_total, h_active, v_total, v_active;
  logic [15:0]   rx_rgb;
  logic [31:0]   frame_chk;
  logic [2:0]    err_flags;

  vga_rx_decoder #(.CW(CW), .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .LOCK_FRAMES(2)) dut (
    .pix_clk(pix_clk), .pix_rst(pix_rst),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
    .frame_done(frame_done), .h_total(h_total), .h_active(h_active),
    .v_total(v_total), .v_active(v_active), .frame_chk(frame_chk),
    .locked(locked), .err_flags(err_flags)
  );

  always #5 pix_clk = ~pix_clk;

  int cyc = 0;
  always @(posedge pix_clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  typedef struct { int stamp; int x; int y; logic [15:0] rgb; } pexp_t;
  typedef struct { int stamp; int ht; int vt; int va; logic [31:0] chk; int err; int lk; } fexp_t;
  pexp_t pq[$];
  fexp_t fq[$];
  fexp_t pend;
  bit    pend_ok = 1'b0;

  // frame kinds: 0 normal, 1 white, 2 short line, 3 DE in vsync, 4 5000-cycle last line, 5 reset mid-frame
  int kind_t [NF] = '{0, 0, 1, 2, 0, 0, 3, 0, 0, 4, 0, 5, 0, 0, 0};
  int ex_ht  [NF] = '{20, 20, 20, 20, 20, 20, 20, 20, 20, 4095, 20, 20, 20, 20, 20};
  int ex_va  [NF] = '{4, 4, 4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4};
  int ex_err [NF] = '{0, 0, 0, 1, 0, 0, 2, 0, 0, 4, 0, 0, 0, 0, 0};
  // 2 = locked not checked for that frame
  int ex_lk  [NF] = '{0, 1, 1, 0, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1};

  task automatic check(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_x"}, rx_x, 0);
    check({tag, "_rx_y"}, rx_y, 0);
    check({tag, "_rx_rgb"}, rx_rgb, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_h_total"}, h_total, 0);
    check({tag, "_h_active"}, h_active, 0);
    check({tag, "_v_total"}, v_total, 0);
    check({tag, "_v_active"}, v_active, 0);
    check({tag, "_frame_chk"}, frame_chk, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err_flags"}, err_flags, 0);
  endtask

  pexp_t mp;
  fexp_t mf;
  always @(negedge pix_clk) begin
    while (pq.size() > 0 && pq[0].stamp < cyc) begin
      mp = pq.pop_front();
      check("pix_missed", cyc, mp.stamp);
    end
    while (fq.size() > 0 && fq[0].stamp < cyc) begin
      mf = fq.pop_front();
      check("frame_done_missed", cyc, mf.stamp);
    end
    if (rx_valid) begin
      if (pq.size() == 0) begin
        check("pix_unexpected", 1, 0);
      end else begin
        mp = pq.pop_front();
        check("pix_latency", cyc, mp.stamp);
        check("rx_x", rx_x, mp.x);
        check("rx_y", rx_y, mp.y);
        check("rx_rgb", rx_rgb, mp.rgb);
      end
    end
    if (frame_done) begin
      if (fq.size() == 0) begin
        check("frame_done_unexpected", 1, 0);
      end else begin
        mf = fq.pop_front();
        check("frame_done_time", cyc, mf.stamp);
        check("h_total", h_total, mf.ht);
        check("h_active", h_active, 8);
        check("v_total", v_total, mf.vt);
        check("v_active", v_active, mf.va);
        check("frame_chk", frame_chk, mf.chk);
        check("err_flags", err_flags, mf.err);
        if (mf.lk != 2) check("locked", locked, mf.lk);
      end
    end
  end

  task automatic drive_frame(input int fi);
    int          k, ht_line, de_len, y, x;
    bit          de_on;
    logic [31:0] chk;
    logic [15:0] pix;
    pexp_t       pe;
    k   = kind_t[fi];
    chk = 32'h0;
    y   = 0;
    for (int v = 0; v < 10; v++) begin
      ht_line = (k == 4 && v == 9) ? 5000 : 20;
      de_on   = (v >= 3 && v <= 6) || (k == 3 && v == 1);
      de_len  = (k == 2 && v == 4) ? 7 : 8;
      for (int h = 0; h < ht_line; h++) begin
        @(posedge pix_clk); #1;
        if (k == 5 && v == 8 && h == 11) check_zero("midrst");
        if (v == 0 && h == 0 && pend_ok) begin
          pend.stamp = cyc + 2;
          fq.push_back(pend);
        end
        pix_rst   = (k == 5 && v == 8 && h == 10);
        vga_hsync = (h < 2) ? 1'b0 : 1'b1;
        vga_vsync = (v < 2) ? 1'b0 : 1'b1;
        if (de_on && h >= 4 && h < 4 + de_len) begin
          x   = h - 4;
          pix = (k == 1) ? 16'hFFFF : 16'(x + 16 * y);
          vga_de  = 1'b1;
          vga_rgb = pix;
          chk = {chk[30:0], chk[31]} ^ {16'h0000, pix};
          pe.stamp = cyc + 2; pe.x = x; pe.y = y; pe.rgb = pix;
          pq.push_back(pe);
        end else begin
          vga_de  = 1'b0;
          vga_rgb = 16'h0000;
        end
      end
      if (de_on) y++;
    end
    pend.ht  = ex_ht[fi];
    pend.vt  = 10;
    pend.va  = ex_va[fi];
    pend.chk = chk;
    pend.err = ex_err[fi];
    pend.lk  = ex_lk[fi];
    pend_ok  = (k != 5);
  endtask

  initial begin
    pix_rst   = 1'b1;
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    vga_de    = 1'b0;
    vga_rgb   = 16'h0000;
    repeat (4) @(posedge pix_clk);
    #1;
    check_zero("rst");
    pix_rst = 1'b0;
    repeat (5) @(posedge pix_clk);
    #1;
    for (int f = 0; f < NF; f++) drive_frame(f);
    repeat (20) begin
      @(posedge pix_clk); #1;
      vga_de = 1'b0;
    end
    check("pix_queue_left", pq.size(), 0);
    check("frame_queue_left", fq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
